// File: rtl/code_lock_fsm_pkg.sv
// Shared types and LED encodings for the keypad code lock.
package code_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    ENTRY,
    UNLOCKED,
    ALARM
  } lock_state_t;

  localparam logic [2:0] RGB_OFF    = 3'b000;
  localparam logic [2:0] RGB_UNLOCK = 3'b010;
  localparam logic [2:0] RGB_ALARM  = 3'b101;

endpackage

// File: rtl/code_lock_fsm_if.sv
// Keypad-side inputs and LED-side outputs of the code lock, bundled for one port.
interface code_lock_fsm_if #(
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned CODE_LEN  = 4,
  parameter int unsigned EXIT_LEN  = 2,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

  logic                         key_valid;
  logic [DIGIT_W-1:0]           key;
  logic [CODE_LEN*DIGIT_W-1:0]  code;
  logic [EXIT_LEN*DIGIT_W-1:0]  exit_code;
  logic [DIGIT_W-1:0]           clear_key;
  logic [CODE_LEN-1:0]          progress;
  logic                         unlocked;
  logic                         alarm;
  logic [FAIL_W-1:0]            fail_count;
  logic [2:0]                   rgb;

  modport master (
    output key_valid, key, code, exit_code, clear_key,
    input  progress, unlocked, alarm, fail_count, rgb
  );

  modport slave (
    input  key_valid, key, code, exit_code, clear_key,
    output progress, unlocked, alarm, fail_count, rgb
  );

endinterface

// File: rtl/code_lock_fsm_timer.sv
// Up-counter with synchronous clear; expire_o flags the cycle the count sits at limit_i.
module lock_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  assign expire_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/code_lock_fsm.sv
// Keypad code lock: N-digit entry with sticky mismatch, failure counting, alarm with exit code,
// inter-key timeout and auto-relock. All outputs are registered decodes of the next state.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned CODE_LEN    = 4,
  parameter int unsigned EXIT_LEN    = 2,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned TIMEOUT_CYC = 100_000_000,
  parameter int unsigned RELOCK_CYC  = 500_000_000
) (
  input  logic           clk,
  input  logic           rst,
  code_lock_fsm_if.slave bus
);

  localparam int unsigned IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned EXI_W  = (EXIT_LEN > 1) ? $clog2(EXIT_LEN) : 1;
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMAX   = (TIMEOUT_CYC > RELOCK_CYC) ? TIMEOUT_CYC : RELOCK_CYC;
  localparam int unsigned TW     = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [EXI_W-1:0]  EXI_LAST  = EXI_W'(EXIT_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
  // Counter starts at 0 on reload, so expiry at LIMIT-1 means exactly LIMIT cycles in the state
  localparam logic [TW-1:0]     TO_LIM    = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]     RL_LIM    = (RELOCK_CYC == 0)  ? '0 : TW'(RELOCK_CYC - 1);

  lock_state_t         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                mism_q, mism_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [EXI_W-1:0]    exit_q, exit_d;
  logic [CODE_LEN-1:0] prog_q, prog_d;
  logic                unl_q, unl_d;
  logic                alm_q, alm_d;
  logic [2:0]          rgb_q, rgb_d;

  logic               done, done_mm;
  logic               tmr_clr, tmr_en, tmr_exp;
  logic [TW-1:0]      tmr_limit;
  logic [DIGIT_W-1:0] first_digit, cur_digit, exit_first, exit_digit;

  assign first_digit = bus.code[(CODE_LEN-1)*DIGIT_W +: DIGIT_W];
  assign cur_digit   = bus.code[(CODE_LEN-1-int'(idx_q))*DIGIT_W +: DIGIT_W];
  assign exit_first  = bus.exit_code[(EXIT_LEN-1)*DIGIT_W +: DIGIT_W];
  assign exit_digit  = bus.exit_code[(EXIT_LEN-1-int'(exit_q))*DIGIT_W +: DIGIT_W];

  assign tmr_en    = ((state_q == ENTRY)    && (TIMEOUT_CYC != 0)) ||
                     ((state_q == UNLOCKED) && (RELOCK_CYC  != 0));
  assign tmr_clr   = bus.key_valid || (state_d != state_q);
  assign tmr_limit = (state_q == UNLOCKED) ? RL_LIM : TO_LIM;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .limit_i  (tmr_limit),
    .expire_o (tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOCKED;
      idx_q   <= '0;
      mism_q  <= 1'b0;
      fail_q  <= '0;
      exit_q  <= '0;
      prog_q  <= '0;
      unl_q   <= 1'b0;
      alm_q   <= 1'b0;
      rgb_q   <= RGB_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mism_q  <= mism_d;
      fail_q  <= fail_d;
      exit_q  <= exit_d;
      prog_q  <= prog_d;
      unl_q   <= unl_d;
      alm_q   <= alm_d;
      rgb_q   <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mism_d  = mism_q;
    fail_d  = fail_q;
    exit_d  = exit_q;
    done    = 1'b0;
    done_mm = 1'b0;
    case (state_q)
      LOCKED: begin
        if (bus.key_valid && (bus.key != bus.clear_key)) begin
          if (CODE_LEN == 1) begin
            done    = 1'b1;
            done_mm = (bus.key != first_digit);
          end else begin
            state_d = ENTRY;
            idx_d   = IDX_W'(1);
            mism_d  = (bus.key != first_digit);
          end
        end
      end
      ENTRY: begin
        if (bus.key_valid) begin
          if (!mism_q && (bus.key == cur_digit)) begin
            done    = (idx_q == IDX_LAST);
            done_mm = 1'b0;
            idx_d   = idx_q + IDX_W'(1);
          end else if (bus.key == bus.clear_key) begin
            state_d = LOCKED;
            idx_d   = '0;
            mism_d  = 1'b0;
          end else begin
            done    = (idx_q == IDX_LAST);
            done_mm = 1'b1;
            mism_d  = 1'b1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else if (tmr_exp) begin
          state_d = LOCKED;
          idx_d   = '0;
          mism_d  = 1'b0;
        end
      end
      UNLOCKED: begin
        if (bus.key_valid || tmr_exp) state_d = LOCKED;
      end
      ALARM: begin
        // A wrong key restarts the exit sequence but may itself be its first digit
        if (bus.key_valid) begin
          if (bus.key == exit_digit) begin
            if (exit_q == EXI_LAST) begin
              state_d = LOCKED;
              fail_d  = '0;
              exit_d  = '0;
            end else begin
              exit_d = exit_q + EXI_W'(1);
            end
          end else if (bus.key == exit_first) begin
            exit_d = EXI_W'(1);
          end else begin
            exit_d = '0;
          end
        end
      end
      default: state_d = LOCKED;
    endcase

    if (done) begin
      idx_d  = '0;
      mism_d = 1'b0;
      if (!done_mm) begin
        state_d = UNLOCKED;
        fail_d  = '0;
      end else if ((fail_q + FAIL_W'(1)) == FAIL_MAX) begin
        state_d = ALARM;
        fail_d  = fail_q + FAIL_W'(1);
      end else begin
        state_d = LOCKED;
        fail_d  = fail_q + FAIL_W'(1);
      end
    end
  end

  always_comb begin
    prog_d = '0;
    unl_d  = 1'b0;
    alm_d  = 1'b0;
    rgb_d  = RGB_OFF;
    case (state_d)
      ENTRY: begin
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
          prog_d[CODE_LEN-1-i] = (i < 32'(idx_d));
        end
      end
      UNLOCKED: begin
        prog_d = '1;
        unl_d  = 1'b1;
        rgb_d  = RGB_UNLOCK;
      end
      ALARM: begin
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
          prog_d[i] = ((i % 2) == 0);
        end
        alm_d = 1'b1;
        rgb_d = RGB_ALARM;
      end
      default: ;
    endcase
  end

  assign bus.progress   = prog_q;
  assign bus.unlocked   = unl_q;
  assign bus.alarm      = alm_q;
  assign bus.fail_count = fail_q;
  assign bus.rgb        = rgb_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm: stimulus queues expected outputs, a monitor checks them
// one cycle after each sampled key (or explicit check request).
module tb_code_lock_fsm;

  typedef struct packed {
    logic [3:0] prog;
    logic       unl;
    logic       alm;
    logic [1:0] fc;
    logic [2:0] rgb;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
  } sb_t;

  logic clk;
  logic rst;
  logic chk_req;
  int   n_vec;
  int   n_miss;
  sb_t  q[$];

  code_lock_fsm_if #(.DIGIT_W(4), .CODE_LEN(4), .EXIT_LEN(2), .MAX_FAILS(3)) bus ();

  code_lock_fsm #(
    .DIGIT_W     (4),
    .CODE_LEN    (4),
    .EXIT_LEN    (2),
    .MAX_FAILS   (3),
    .TIMEOUT_CYC (20),
    .RELOCK_CYC  (30)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t E(input logic [3:0] p, input logic u, input logic a,
                             input logic [1:0] f, input logic [2:0] c);
    exp_t r;
    r.prog = p; r.unl = u; r.alm = a; r.fc = f; r.rgb = c;
    return r;
  endfunction

  function automatic exp_t L(input logic [1:0] f);
    return E(4'b0000, 1'b0, 1'b0, f, 3'b000);
  endfunction

  function automatic exp_t N(input logic [3:0] p, input logic [1:0] f);
    return E(p, 1'b0, 1'b0, f, 3'b000);
  endfunction

  function automatic exp_t U();
    return E(4'b1111, 1'b1, 1'b0, 2'd0, 3'b010);
  endfunction

  function automatic exp_t A();
    return E(4'b0101, 1'b0, 1'b1, 2'd3, 3'b101);
  endfunction

  function automatic exp_t actual();
    return E(bus.progress, bus.unlocked, bus.alarm, bus.fail_count, bus.rgb);
  endfunction

  // Monitor: any cycle where a key or a check request was sampled yields one comparison.
  initial begin
    sb_t  s;
    exp_t a;
    forever begin
      @(posedge clk);
      if (!rst && (bus.key_valid || chk_req)) begin
        @(negedge clk);
        n_vec++;
        a = actual();
        if (q.size() == 0) begin
          n_miss++;
          $display("FAIL scoreboard_empty: got %h, required an expected entry", a);
        end else begin
          s = q.pop_front();
          if (a !== s.e) begin
            n_miss++;
            $display("FAIL %s: got prog=%b unl=%b alm=%b fc=%0d rgb=%b, required prog=%b unl=%b alm=%b fc=%0d rgb=%b",
                     s.tag, a.prog, a.unl, a.alm, a.fc, a.rgb,
                     s.e.prog, s.e.unl, s.e.alm, s.e.fc, s.e.rgb);
          end
        end
      end
    end
  end

  task automatic step(input logic kv, input logic [3:0] k, input logic chk,
                      input exp_t e, input string tag);
    sb_t s;
    @(negedge clk);
    bus.key_valid = kv;
    bus.key       = k;
    chk_req       = chk;
    if (kv || chk) begin
      s.e   = e;
      s.tag = tag;
      q.push_back(s);
    end
  endtask

  task automatic press(input logic [3:0] k, input exp_t e, input string tag);
    step(1'b1, k, 1'b0, e, tag);
  endtask

  task automatic peek(input exp_t e, input string tag);
    step(1'b0, 4'h0, 1'b1, e, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, L(2'd0), "");
  endtask

  task automatic check_now(input exp_t e, input string tag);
    exp_t a;
    a = actual();
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", tag, a, e);
    end
  endtask

  // Async reset pulse inside the low clock phase, checked before any clock edge.
  task automatic pulse_reset(input string tag);
    idle(2);
    #2 rst = 1'b1;
    #1 check_now(L(2'd0), tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fail_attempt(input logic [1:0] f);
    press(4'h4, N(4'b1000, f), "bad_d0");
    press(4'h1, N(4'b1100, f), "bad_d1");
    press(4'h2, N(4'b1110, f), "bad_d2");
    if (f == 2'd2) press(4'h2, A(), "bad_alarm");
    else           press(4'h2, L(f + 2'd1), "bad_d3");
  endtask

  task automatic unlock(input logic [1:0] f, input string tag);
    press(4'h4, N(4'b1000, f), {tag, "_d0"});
    press(4'h1, N(4'b1100, f), {tag, "_d1"});
    press(4'h2, N(4'b1110, f), {tag, "_d2"});
    press(4'h1, U(), {tag, "_open"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    rst           = 1'b1;
    chk_req       = 1'b0;
    bus.key_valid = 1'b0;
    bus.key       = 4'h0;
    bus.code      = 16'h4121;
    bus.exit_code = 8'h12;
    bus.clear_key = 4'hF;
    #3 check_now(L(2'd0), "reset_state");
    @(negedge clk);
    rst = 1'b0;

    press(4'hF, L(2'd0), "clear_in_locked");
    unlock(2'd0, "ok");
    press(4'h0, L(2'd0), "key_relocks");

    press(4'h4, N(4'b1000, 2'd0), "abort_d0");
    press(4'h1, N(4'b1100, 2'd0), "abort_d1");
    press(4'hF, L(2'd0), "abort_clear");
    unlock(2'd0, "after_abort");
    press(4'h5, L(2'd0), "relock2");

    press(4'h5, N(4'b1000, 2'd0), "mm_d0");
    press(4'h1, N(4'b1100, 2'd0), "mm_sticky_d1");
    press(4'h2, N(4'b1110, 2'd0), "mm_sticky_d2");
    press(4'h1, L(2'd1), "mm_fail1");
    unlock(2'd1, "clears_fails");
    press(4'h0, L(2'd0), "relock3");

    fail_attempt(2'd0);
    fail_attempt(2'd1);
    fail_attempt(2'd2);
    press(4'h1, A(), "exit_1");
    press(4'hF, A(), "exit_reset_by_F");
    press(4'h2, A(), "exit_wrong_2");
    press(4'h1, A(), "exit_again_1");
    press(4'h1, A(), "exit_recheck_1");
    press(4'h2, L(2'd0), "exit_done");

    press(4'h5, N(4'b1000, 2'd0), "pre_to_d0");
    press(4'h5, N(4'b1100, 2'd0), "pre_to_d1");
    press(4'h5, N(4'b1110, 2'd0), "pre_to_d2");
    press(4'h5, L(2'd1), "pre_to_fail");
    press(4'h4, N(4'b1000, 2'd1), "to_d0");
    press(4'h1, N(4'b1100, 2'd1), "to_d1");
    idle(18);
    peek(N(4'b1100, 2'd1), "to_before_expiry");
    peek(L(2'd1), "to_expired_fails_kept");

    unlock(2'd1, "rl");
    idle(28);
    peek(U(), "relock_before_expiry");
    peek(L(2'd0), "relock_expired");

    press(4'h4, N(4'b1000, 2'd0), "kw_d0");
    press(4'h1, N(4'b1100, 2'd0), "kw_d1");
    idle(19);
    press(4'h2, N(4'b1110, 2'd0), "key_wins_over_timeout");
    press(4'h1, U(), "kw_open");
    press(4'h0, L(2'd0), "kw_relock");

    press(4'h4, N(4'b1000, 2'd0), "rst_e_d0");
    press(4'h1, N(4'b1100, 2'd0), "rst_e_d1");
    pulse_reset("reset_mid_entry");

    fail_attempt(2'd0);
    fail_attempt(2'd1);
    fail_attempt(2'd2);
    pulse_reset("reset_in_alarm");
    unlock(2'd0, "post_reset");

    idle(3);
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/code_lock_fsm.md
# code_lock_fsm

Parametrised keypad lock controller: compares a stream of debounced key codes against a programmable N-digit code, counts consecutive failed attempts, raises an alarm after a configurable number of failures, and clears the alarm on a separate exit sequence. It sits between the keypad scanner/debouncer and the board LEDs/RGB driver. It generalises the fixed 4-digit lock with per-digit index and failure counters, and adds inter-key timeout and auto-relock.

## Interface
- DIGIT_W, 4, bits per key code
- CODE_LEN, 4, digits in the unlock code (≥1)
- EXIT_LEN, 2, digits in the alarm exit code (≥1)
- MAX_FAILS, 3, failed complete attempts that trigger the alarm (≥1)
- TIMEOUT_CYC, 100_000_000, idle cycles allowed between keys during entry; 0 disables
- RELOCK_CYC, 500_000_000, cycles in UNLOCKED before automatic relock; 0 disables

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key_valid  in  1  one-cycle pulse per key press
- key  in  DIGIT_W  key code, sampled when key_valid=1
- code  in  CODE_LEN*DIGIT_W  unlock code; digit 0 in the MSBs
- exit_code  in  EXIT_LEN*DIGIT_W  alarm exit code; digit 0 in the MSBs
- clear_key  in  DIGIT_W  abort/re-enter key
- progress  out  CODE_LEN  entry progress, thermometer from MSB
- unlocked  out  1  high in UNLOCKED
- alarm  out  1  high in ALARM
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed attempts
- rgb  out  3  {R,G,B}: 010 unlocked, 101 alarm, 000 otherwise

## Operation
- States: LOCKED, ENTRY, UNLOCKED, ALARM. Registers: idx (digit index), mismatch (sticky flag), fail_cnt, exit_idx, timer.
- LOCKED: key_valid with key==clear_key → stay. Any other key is digit 0 → ENTRY, idx=1, mismatch=(key!=code digit 0).
- ENTRY, per key_valid, priority order: (1) !mismatch and key==code[idx] → digit accepted; (2) key==clear_key → LOCKED, idx=0, mismatch=0, fail_cnt unchanged; (3) otherwise → mismatch=1, digit consumed.
- After the CODE_LEN-th consumed digit: mismatch=0 → UNLOCKED, fail_cnt=0. mismatch=1 → fail_cnt+1; if that equals MAX_FAILS → ALARM, else → LOCKED.
- CODE_LEN=1: decision is made on the first key, directly from LOCKED.
- Entry timeout: TIMEOUT_CYC cycles in ENTRY without key_valid → LOCKED. The attempt is abandoned and not counted.
- UNLOCKED: any key_valid, or RELOCK_CYC expiry → LOCKED.
- ALARM: key==exit_code[exit_idx] → exit_idx+1. Wrong key → exit_idx=0, then the same key is re-checked against exit digit 0. Completing EXIT_LEN digits → LOCKED, fail_cnt=0, exit_idx=0. Timeouts are not active in ALARM.
- Outputs:
  - progress: LOCKED/UNLOCKED give all-zeros / all-ones; ENTRY gives idx ones from MSB; ALARM gives alternating 0101… (LSB=1).
- Reset (any time, including mid-entry or in alarm): state=LOCKED. idx, mismatch, fail_cnt, exit_idx, timer = 0. All outputs 0.

## Timing
- key_valid is sampled on the rising clk edge. State and counters update on that edge.
- All outputs are registered Moore decodes and are valid the cycle after the sampling edge (1-cycle latency).
- Back-to-back key_valid on consecutive cycles must each be processed; there is no dead cycle.
- Timer reloads on entry to ENTRY/UNLOCKED and on every key_valid in ENTRY. Expiry acts on the cycle the count reaches TIMEOUT_CYC (or RELOCK_CYC).
- If key_valid and timer expiry occur in the same cycle, key_valid wins.
- Timer width is $clog2(max(TIMEOUT_CYC,RELOCK_CYC)+1).

## Structure
- Package code_lock_pkg holds:
  - lock_state_t enum {LOCKED, ENTRY, UNLOCKED, ALARM}
  - RGB_OFF, RGB_UNLOCK, RGB_ALARM constants
- Sub-module lock_timer: loadable up-counter with clear, enable and expire, parameterised by width.
- Digit selection uses an indexed part-select on code/exit_code; no per-digit states.

## Test plan
Common setup: CODE_LEN=4, DIGIT_W=4, code=16'h4121, clear_key=4'hF, exit_code=8'h12, MAX_FAILS=3, small timeouts.
- Keys 4,1,2,1 → progress 1000,1100,1110; unlocked=1, rgb=010, fail_count=0 one cycle after the last key.
- Keys 4,1,F,4,1,2,1 → after F: LOCKED, progress 0000, fail_count 0; then unlocked=1.
- Three attempts of 4,1,2,2 → fail_count 1, 2, then alarm=1, rgb=101, progress 0101. Then keys 1,1,2 → wrong 1 re-checked as digit 0, exit completes, LOCKED, fail_count=0.
- Keys 4,1, then idle TIMEOUT_CYC → LOCKED, fail_count unchanged. Unlock, idle RELOCK_CYC → unlocked=0. Key_valid on the expiry cycle → key processed.
- Assert rst mid-entry (after 4,1) and in ALARM → all outputs 0 asynchronously. A subsequent 4,1,2,1 unlocks.
